deser8_demux: RTL and testbench
===============================

Name: deser8_demux

Overview:
- Serial-to-parallel converter: the receive end of a bit stream produced by a counter-driven 8:1 mux serializer.
- Accepts one bit per cycle under a valid/ready handshake.
- Routes each bit into one of 8 byte-lane flops through a 3-to-8 decoder driven by a 3-bit bit counter.
- Presents each completed byte on an output valid/ready interface, with one extra byte of buffering so the serial side is not stalled while the consumer drains.

Parameters:
- MSB_FIRST, 0, 0: first received bit lands in byte[0] (lane index = counter). 1: first bit lands in byte[7] (lane index = 7 - counter).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  block can accept a bit this cycle
- clear  input  1  synchronous abort of the partially assembled byte
- byte_out  output  8  assembled byte
- byte_valid  output  1  byte_out holds a valid byte
- byte_ready  input  1  consumer accepts byte_out this cycle
- bit_index  output  3  current counter value, i.e. the lane the next accepted bit will fill (before MSB_FIRST mapping)

Behaviour:
- Reset, when reset_n = 0 at a clock edge:
  - Counter cleared to 0, assembly register to 0x00, pending flag to 0.
  - byte_out = 0x00, byte_valid = 0, bit_index = 0.
  - bit_ready = 1 from the first cycle after reset release.
- Reset mid-byte or mid-stall discards everything. No byte is emitted.
- Accept event: bit_valid && bit_ready.
  - The decoder enables exactly one assembly lane; that lane captures bit_in.
  - All other lanes hold.
  - The counter increments modulo 8 (7 wraps to 0).
- bit_ready = !pending && !clear. This is combinational from registered state plus clear.
- Byte completion happens on the accept with counter = 7. The completed byte is the 7 held lanes plus the incoming bit. Then:
  - Case A, output register empty, or byte_valid && byte_ready in the same cycle: load byte_out with the completed byte and set byte_valid next cycle. Latency is 1 cycle from the 8th accept to byte_valid.
  - Case B, otherwise: the completed byte stays in the assembly register, pending = 1, and bit_ready drops the next cycle.
- Drain: byte_valid && byte_ready.
  - If pending: byte_out loads from the assembly register, pending clears, byte_valid stays 1, and bit_ready rises the next cycle.
  - Else if no Case A load this cycle: byte_valid = 0. byte_out holds its last value.
- byte_out and byte_valid are stable while byte_valid && !byte_ready.
- Throughput: with byte_ready held at 1, 1 bit/cycle is sustained indefinitely, and byte_valid pulses for 1 cycle every 8 cycles.
- clear:
  - Counter goes to 0 and the assembly register to 0x00.
  - Pending clears; a pending completed byte is discarded.
  - The output register and byte_valid are unaffected, and a drain in the same cycle still completes.
  - clear has priority over a simultaneous bit_valid. bit_ready is 0 during clear, so no bit is accepted.
- Priority per cycle: reset > clear > accept/drain.
- No combinational path from bit_in to byte_out. byte_out is always a registered output.

Test Plan:
- Reset then stream bits 1,0,1,1,0,0,1,0 (MSB_FIRST = 0) with byte_ready = 1 -> byte_valid high exactly 1 cycle after the 8th bit, byte_out = 0x4D; bit_index returns to 0.
- Same stream with MSB_FIRST = 1 -> byte_out = 0xB2.
- Back-to-back 24 bits forming 0xA5, 0x3C, 0xFF with byte_ready = 1 -> three 1-cycle byte_valid pulses 8 cycles apart, bit_ready never deasserts.
- byte_ready = 0, stream 16 bits (0x11 then 0x22) -> byte_out = 0x11 held; bit_ready = 0 from the cycle after the 16th bit. Raise byte_ready for 1 cycle -> byte_out = 0x22, byte_valid stays 1, bit_ready = 1 the next cycle.
- Send 5 bits, assert clear together with bit_valid = 1, then send 8 bits forming 0x5A -> the bit in the clear cycle is not accepted and bit_index = 0 after clear; the next byte_out is 0x5A.
- Send 3 bits of a byte, then reset_n = 0 for 1 cycle -> byte_valid = 0, byte_out = 0x00, bit_index = 0, no spurious byte after reset release.

Source files
------------

// File: rtl/deser8_demux.sv
// Serial-to-parallel receiver: one bit per accept is steered into a byte lane by a
// 3-bit counter; completed bytes go to a registered output with one byte of overflow.
module deser8_demux #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       clear,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [2:0] bit_index
);

    logic [2:0] cnt;
    logic [7:0] asm_reg;
    logic       pending;
    logic [7:0] out_reg;
    logic       out_valid;

    logic [2:0] lane;
    logic [7:0] lane_sel;
    logic [7:0] asm_next;
    logic       accept;
    logic       drain;
    logic       complete;
    logic       load_now;

    assign bit_ready  = !pending && !clear;
    assign byte_out   = out_reg;
    assign byte_valid = out_valid;
    assign bit_index  = cnt;

    always_comb begin
        lane     = MSB_FIRST ? (3'd7 - cnt) : cnt;
        lane_sel = 8'b0000_0001 << lane;
        // Only the decoded lane takes bit_in; the other seven hold.
        asm_next = (asm_reg & ~lane_sel) | (bit_in ? lane_sel : '0);
        accept   = bit_valid && bit_ready;
        drain    = out_valid && byte_ready;
        complete = accept && (cnt == 3'd7);
        load_now = complete && (!out_valid || drain);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            asm_reg   <= '0;
            pending   <= 1'b0;
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            asm_reg <= '0;
            pending <= 1'b0;
            // A pending byte is dropped, so a same-cycle drain empties the output.
            if (drain) begin
                out_valid <= 1'b0;
            end
        end else begin
            if (accept) begin
                cnt     <= cnt + 3'd1;
                asm_reg <= asm_next;
            end
            if (load_now) begin
                out_reg   <= asm_next;
                out_valid <= 1'b1;
            end else if (complete) begin
                pending <= 1'b1;
            end
            if (drain && !load_now) begin
                if (pending) begin
                    out_reg <= asm_reg;
                    pending <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_deser8_demux.sv
// Scoreboard bench for deser8_demux: both lane orders run side by side against a
// transaction-level model (bit queue plus a two-deep completed-byte buffer).
module tb_deser8_demux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       byte_ready;
    logic       bit_ready0, bit_ready1;
    logic [7:0] byte_out0, byte_out1;
    logic       byte_valid0, byte_valid1;
    logic [2:0] bit_index0, bit_index1;

    always #5 clk = ~clk;

    deser8_demux #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready0), .clear(clear), .byte_out(byte_out0),
        .byte_valid(byte_valid0), .byte_ready(byte_ready), .bit_index(bit_index0)
    );

    deser8_demux #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready1), .clear(clear), .byte_out(byte_out1),
        .byte_valid(byte_valid1), .byte_ready(byte_ready), .bit_index(bit_index1)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          started  = 1'b0;

    int         occ = 0;
    bit         bits_q[$];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] pack_bits(input bit msb);
        int unsigned v = 0;
        for (int i = 0; i < 8; i++) begin
            if (bits_q[i]) v += msb ? (1 << (7 - i)) : (1 << i);
        end
        return v[7:0];
    endfunction

    // One clock: drive inputs, let the edge happen, then advance the model.
    task automatic step(input logic v, input logic b, input logic c, input logic r, input logic rn);
        bit acc;
        bit drn;
        bit_valid  = v;
        bit_in     = b;
        clear      = c;
        byte_ready = r;
        reset_n    = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            occ = 0;
            bits_q.delete();
            sb0.delete();
            sb1.delete();
            chk("reset_byte_out_lsb", byte_out0, 0);
            chk("reset_byte_out_msb", byte_out1, 0);
            chk("reset_byte_valid", byte_valid0 | byte_valid1, 0);
            chk("reset_bit_index", bit_index0 | bit_index1, 0);
        end else begin
            acc = v && (occ < 2) && !c;
            drn = (occ > 0) && r;
            if (c) begin
                bits_q.delete();
                if (occ == 2) begin
                    void'(sb0.pop_back());
                    void'(sb1.pop_back());
                    occ--;
                end
                if (drn) occ--;
            end else begin
                if (drn) occ--;
                if (acc) begin
                    bits_q.push_back(b);
                    if (bits_q.size() == 8) begin
                        sb0.push_back(pack_bits(1'b0));
                        sb1.push_back(pack_bits(1'b1));
                        bits_q.delete();
                        occ++;
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input logic r);
        logic [7:0] tmp;
        tmp = val;
        for (int i = 0; i < 8; i++) step(1'b1, tmp[i], 1'b0, r, 1'b1);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (started && reset_n === 1'b1) begin
                chk("bit_ready_lsb", bit_ready0, (occ < 2) && !clear);
                chk("bit_ready_msb", bit_ready1, (occ < 2) && !clear);
                chk("byte_valid_lsb", byte_valid0, occ > 0);
                chk("byte_valid_msb", byte_valid1, occ > 0);
                chk("bit_index_lsb", bit_index0, bits_q.size());
                chk("bit_index_msb", bit_index1, bits_q.size());
                if (occ > 0) begin
                    if (sb0.size() == 0 || sb1.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        chk("byte_out_lsb", byte_out0, sb0[0]);
                        chk("byte_out_msb", byte_out1, sb1[0]);
                        if (byte_ready) begin
                            void'(sb0.pop_front());
                            void'(sb1.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        clear      = 1'b0;
        byte_ready = 1'b0;
        reset_n    = 1'b0;
        started    = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1,0,1,1,0,0,1,0 -> 0x4D lsb-first, 0xB2 msb-first
        send_byte(8'h4D, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stall: second byte waits in the assembly register
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Partial byte, clear with a competing bit, then a full byte
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_byte(8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-byte
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 299) != 0);
        end

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("final_sb_empty_lsb", sb0.size(), 0);
        chk("final_sb_empty_msb", sb1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
